// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: accumulates a stream of operands in carry-save form, then resolves with one carry-propagate add
module csa_accum_ctrl #(
   parameter int WIDTH   = 4,
   parameter int OPS_MAX = 8,
   parameter int CNT_W   = 4,
   parameter int RES_W   = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_ops,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [RES_W-1:0] out_sum,
   input  logic             out_ready,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
   state_t state_q, state_d;
   logic [RES_W-1:0] sum_q, sum_d, car_q, car_d, res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
   logic [RES_W-1:0] x;
   logic [CNT_W-1:0] tgt_sat;
   assign x         = {{(RES_W-WIDTH){1'b0}}, in_data};
   assign tgt_sat   = (num_ops > CNT_W'(OPS_MAX)) ? CNT_W'(OPS_MAX) : num_ops;
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_sum   = res_q;
   // next state: one 3:2 layer per accepted operand, single resolve add after the last one
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      car_d   = car_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: if (start) begin
            tgt_d   = tgt_sat;
            sum_d   = '0;
            car_d   = '0;
            cnt_d   = '0;
            state_d = (tgt_sat == '0) ? RESOLVE : ACCUM;
         end
         ACCUM: if (in_valid) begin
            sum_d   = sum_q ^ car_q ^ x;
            car_d   = ((sum_q & car_q) | (sum_q & x) | (car_q & x)) << 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = ((cnt_q + 1'b1) == tgt_q) ? RESOLVE : ACCUM;
         end
         RESOLVE: begin
            res_d   = sum_q + car_q;
            state_d = DONE;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // state registers with synchronous reset discarding any job in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sum_q   <= '0;
         car_q   <= '0;
         cnt_q   <= '0;
         tgt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         car_q   <= car_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         res_q   <= res_d;
      end
   end
endmodule
